// File: rtl/mem_arbiter.sv
// Serialises per-core I/D cache ports onto one RAM port; D beats I, round-robin per class.
// Define MEMARB_STATS_EN to add the stat_grants/stat_stalls counters.
module mem_arbiter #(
    parameter int CPUS = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [CPUS-1:0]    iREN,
    input  logic [CPUS*AW-1:0] iaddr,
    output logic [CPUS-1:0]    iwait,
    output logic [CPUS*DW-1:0] iload,
    input  logic [CPUS-1:0]    dREN,
    input  logic [CPUS-1:0]    dWEN,
    input  logic [CPUS*AW-1:0] daddr,
    input  logic [CPUS*DW-1:0] dstore,
    output logic [CPUS-1:0]    dwait,
    output logic [CPUS*DW-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [AW-1:0]      ramaddr,
    output logic [DW-1:0]      ramstore,
    input  logic [DW-1:0]      ramload,
    input  logic [1:0]        ramstate
`ifdef MEMARB_STATS_EN
    ,
    output logic [31:0]       stat_grants,
    output logic [31:0]       stat_stalls
`endif
);
    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] ACCESS = 2'd2;

    typedef enum logic {IDLE, XFER} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_owner, w_owner;
    logic          r_is_d, w_is_d;
    logic [CW-1:0] r_rr_d, r_rr_i, w_rr_d, w_rr_i;
    logic [CPUS-1:0] w_dreq, w_drot, w_irot;
    logic [CW-1:0] w_d_sel, w_i_sel, w_inc;
    logic [AW-1:0] w_oaddr;
    logic [DW-1:0] w_ostore;
    logic          w_oren, w_owen, w_act, w_done;

    assign w_dreq = dREN | dWEN;
    assign w_drot = CPUS'({w_dreq, w_dreq} >> r_rr_d);
    assign w_irot = CPUS'({iREN, iREN} >> r_rr_i);

    // Rotated scan: the lowest set bit after the pointer wins.
    always_comb begin : pick
        w_d_sel = r_rr_d;
        w_i_sel = r_rr_i;
        for (int k = CPUS - 1; k >= 0; k--) begin
            if (w_drot[k]) w_d_sel = CW'((int'(r_rr_d) + k) % CPUS);
            if (w_irot[k]) w_i_sel = CW'((int'(r_rr_i) + k) % CPUS);
        end
    end

    always_comb begin : owner_mux
        w_oaddr  = '0;
        w_ostore = '0;
        w_oren   = 1'b0;
        w_owen   = 1'b0;
        for (int c = 0; c < CPUS; c++) begin
            if (r_owner == CW'(c)) begin
                if (r_is_d) begin
                    w_oaddr  = daddr[c*AW +: AW];
                    w_ostore = dstore[c*DW +: DW];
                    w_owen   = dWEN[c];
                    w_oren   = dREN[c] & ~dWEN[c];
                end else begin
                    w_oaddr = iaddr[c*AW +: AW];
                    w_oren  = iREN[c];
                end
            end
        end
    end

    assign w_act  = w_oren | w_owen;
    assign w_done = (r_state == XFER) && w_act && (ramstate == ACCESS);
    assign w_inc  = (r_owner == CW'(CPUS - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin : fsm
        w_next   = r_state;
        w_owner  = r_owner;
        w_is_d   = r_is_d;
        w_rr_d   = r_rr_d;
        w_rr_i   = r_rr_i;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        unique case (r_state)
            IDLE: begin
                if (|w_dreq) begin
                    w_next  = XFER;
                    w_owner = w_d_sel;
                    w_is_d  = 1'b1;
                end else if (|iREN) begin
                    w_next  = XFER;
                    w_owner = w_i_sel;
                    w_is_d  = 1'b0;
                end
            end
            XFER: begin
                // A dropped request aborts without touching the pointers.
                if (!w_act) begin
                    w_next = IDLE;
                end else begin
                    ramREN   = w_oren;
                    ramWEN   = w_owen;
                    ramaddr  = w_oaddr;
                    ramstore = w_ostore;
                end
                if (w_done) begin
                    w_next = IDLE;
                    if (r_is_d) w_rr_d = w_inc;
                    else        w_rr_i = w_inc;
                    for (int c = 0; c < CPUS; c++) begin
                        if (r_owner == CW'(c)) begin
                            if (r_is_d) begin
                                dwait[c]          = 1'b0;
                                dload[c*DW +: DW] = ramload;
                            end else begin
                                iwait[c]          = 1'b0;
                                iload[c*DW +: DW] = ramload;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_is_d  <= 1'b0;
            r_rr_d  <= '0;
            r_rr_i  <= '0;
        end else begin
            r_state <= w_next;
            r_owner <= w_owner;
            r_is_d  <= w_is_d;
            r_rr_d  <= w_rr_d;
            r_rr_i  <= w_rr_i;
        end
    end

`ifdef MEMARB_STATS_EN
    logic w_stall;
    assign w_stall = ((|w_dreq) | (|iREN)) & (&iwait) & (&dwait);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            if (w_done && stat_grants != 32'hFFFF_FFFF)
                stat_grants <= stat_grants + 32'd1;
            if (w_stall && stat_stalls != 32'hFFFF_FFFF)
                stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected RAM transactions are queued at stimulus
// time and popped when the arbiter serves them.
module tb_mem_arbiter;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  iREN, dREN, dWEN;
    logic [63:0] iaddr, daddr, dstore;
    logic [1:0]  iwait, dwait;
    logic [63:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
`ifdef MEMARB_STATS_EN
    logic [31:0] stat_grants, stat_stalls;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          d;
        int          core;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t sq[$];

    always #5 CLK = ~CLK;

    mem_arbiter #(.CPUS(2), .AW(32), .DW(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
`ifdef MEMARB_STATS_EN
        , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
    );

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            errors++;
            $display("FAIL reset_ram: ren=%b wen=%b addr=%h store=%h, want all 0", ramREN, ramWEN, ramaddr, ramstore);
        end
        checks++;
        if (iwait !== 2'b11 || dwait !== 2'b11 || iload !== 64'h0 || dload !== 64'h0) begin
            errors++;
            $display("FAIL reset_ports: iwait=%b dwait=%b iload=%h dload=%h, want 11/11/0/0", iwait, dwait, iload, dload);
        end
`ifdef MEMARB_STATS_EN
        checks++;
        if (stat_grants !== 32'h0 || stat_stalls !== 32'h0) begin
            errors++;
            $display("FAIL reset_stats: grants=%0d stalls=%0d, want 0/0", stat_grants, stat_stalls);
        end
`endif
        next_cycle();
        nRST = 1'b1;
    endtask

    task automatic test_single_iread();
        txn_t e;
        iREN = 2'b01;
        iaddr[31:0] = 32'h40;
        ramstate = 2'd0;
        sq.push_back('{d: 1'b0, core: 0, we: 1'b0, addr: 32'h40, data: 32'h0});
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle: ramREN=%b, want 0", ramREN);
        end
        next_cycle();
        ramstate = 2'd1;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 2'b11) begin
            errors++;
            $display("FAIL t1_busy: ren=%b addr=%h iwait=%b, want 1/40/11", ramREN, ramaddr, iwait);
        end
        next_cycle();
        ramstate = 2'd2;
        ramload = 32'hDEAD_BEEF;
        @(negedge CLK);
        e = sq.pop_front();
        checks++;
        if (ramaddr !== e.addr || iwait !== 2'b10 || iload !== {32'h0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL t1_access: addr=%h iwait=%b iload=%h, want %h/10/DEADBEEF", ramaddr, iwait, iload, e.addr);
        end
        next_cycle();
        iREN = 2'b00;
        ramstate = 2'd0;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0 || iwait !== 2'b11) begin
            errors++;
            $display("FAIL t1_back_idle: ren=%b iwait=%b, want 0/11", ramREN, iwait);
        end
        next_cycle();
    endtask

    task automatic test_d_beats_i();
        txn_t e;
        logic [1:0]  m;
        logic [63:0] el;
        int last = -1;
        bit drop;
        iREN = 2'b01;
        iaddr[31:0] = 32'h44;
        dWEN = 2'b10;
        daddr[63:32] = 32'h80;
        dstore[63:32] = 32'h1234;
        ramstate = 2'd2;
        sq.push_back('{d: 1'b1, core: 1, we: 1'b1, addr: 32'h80, data: 32'h1234});
        sq.push_back('{d: 1'b0, core: 0, we: 1'b0, addr: 32'h44, data: 32'h0});
        for (int cyc = 0; cyc < 20 && sq.size() > 0; cyc++) begin
            ramload = $urandom;
            drop = 1'b0;
            @(negedge CLK);
            if (ramREN || ramWEN) begin
                e = sq.pop_front();
                m = 2'b01 << e.core;
                el = '0;
                el[e.core*32 +: 32] = ramload;
                drop = 1'b1;
                checks++;
                if (ramaddr !== e.addr || ramWEN !== e.we || ramREN !== !e.we) begin
                    errors++;
                    $display("FAIL t2_order: addr=%h wen=%b ren=%b, want addr=%h wen=%b", ramaddr, ramWEN, ramREN, e.addr, e.we);
                end
                if (e.we) begin
                    checks++;
                    if (ramstore !== e.data) begin
                        errors++;
                        $display("FAIL t2_store: ramstore=%h, want %h", ramstore, e.data);
                    end
                end
                checks++;
                if (e.d ? (dwait !== ~m || iwait !== 2'b11)
                        : (iwait !== ~m || dwait !== 2'b11 || iload !== el)) begin
                    errors++;
                    $display("FAIL t2_wait: iwait=%b dwait=%b iload=%h, want served core %0d d=%b", iwait, dwait, iload, e.core, e.d);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 2) begin
                        errors++;
                        $display("FAIL t2_gap: %0d cycles between grants, want 2", cyc - last);
                    end
                end
                last = cyc;
            end
            next_cycle();
            if (drop) begin
                if (e.d) dWEN[e.core] = 1'b0;
                else     iREN[e.core] = 1'b0;
            end
        end
        checks++;
        if (sq.size() != 0) begin
            errors++;
            $display("FAIL t2_timeout: %0d transactions unserved, want 0", sq.size());
        end
        sq.delete();
        ramstate = 2'd0;
    endtask

    task automatic test_round_robin();
        txn_t e;
        logic [1:0]  m;
        logic [63:0] el;
        int last = -1;
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        dREN = 2'b11;
        daddr = {32'h204, 32'h200};
        ramstate = 2'd2;
        for (int g = 0; g < 4; g++)
            sq.push_back('{d: 1'b1, core: g % 2, we: 1'b0, addr: 32'h200 + 32'(4 * (g % 2)), data: 32'h0});
        for (int cyc = 0; cyc < 30 && sq.size() > 0; cyc++) begin
            ramload = $urandom;
            @(negedge CLK);
            if (ramREN || ramWEN) begin
                e = sq.pop_front();
                m = 2'b01 << e.core;
                el = '0;
                el[e.core*32 +: 32] = ramload;
                checks++;
                if (ramaddr !== e.addr || ramREN !== 1'b1 || dwait !== ~m || dload !== el) begin
                    errors++;
                    $display("FAIL t3_rr: addr=%h ren=%b dwait=%b dload=%h, want core %0d addr %h", ramaddr, ramREN, dwait, dload, e.core, e.addr);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 2) begin
                        errors++;
                        $display("FAIL t3_gap: %0d cycles between grants, want 2", cyc - last);
                    end
                end
                last = cyc;
            end
            next_cycle();
        end
        checks++;
        if (sq.size() != 0) begin
            errors++;
            $display("FAIL t3_timeout: %0d grants missing, want 0", sq.size());
        end
        sq.delete();
        dREN = 2'b00;
        ramstate = 2'd0;
`ifdef MEMARB_STATS_EN
        @(negedge CLK);
        checks++;
        if (stat_grants !== 32'd4 || stat_stalls !== 32'd4) begin
            errors++;
            $display("FAIL t6_stats: grants=%0d stalls=%0d, want 4/4", stat_grants, stat_stalls);
        end
        next_cycle();
`endif
    endtask

    task automatic test_error_retry();
        txn_t e;
        dREN = 2'b10;
        daddr[63:32] = 32'h300;
        ramstate = 2'd0;
        sq.push_back('{d: 1'b1, core: 1, we: 1'b0, addr: 32'h300, data: 32'h0});
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0) begin
            errors++;
            $display("FAIL t4_idle: ramREN=%b, want 0", ramREN);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            ramstate = 2'd3;
            @(negedge CLK);
            checks++;
            if (ramREN !== 1'b1 || ramaddr !== 32'h300 || dwait !== 2'b11) begin
                errors++;
                $display("FAIL t4_err_hold%0d: ren=%b addr=%h dwait=%b, want 1/300/11", i, ramREN, ramaddr, dwait);
            end
        end
        next_cycle();
        ramstate = 2'd2;
        ramload = 32'hCAFE_0004;
        @(negedge CLK);
        e = sq.pop_front();
        checks++;
        if (ramaddr !== e.addr || ramREN !== 1'b1 || dwait !== 2'b01 || dload !== {32'hCAFE_0004, 32'h0}) begin
            errors++;
            $display("FAIL t4_served: addr=%h ren=%b dwait=%b dload=%h, want %h/1/01/CAFE0004", ramaddr, ramREN, dwait, dload, e.addr);
        end
        next_cycle();
        dREN = 2'b00;
        ramstate = 2'd0;
    endtask

    task automatic test_abort_reset();
        dREN = 2'b01;
        daddr[31:0] = 32'h400;
        ramstate = 2'd1;
        @(negedge CLK);
        next_cycle();
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h400) begin
            errors++;
            $display("FAIL t5_xfer: ren=%b addr=%h, want 1/400", ramREN, ramaddr);
        end
        next_cycle();
        dREN = 2'b00;
        iREN = 2'b10;
        iaddr[63:32] = 32'h480;
        ramstate = 2'd2;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 2'b11 || iwait !== 2'b11) begin
            errors++;
            $display("FAIL t5_abort: ren=%b wen=%b dwait=%b iwait=%b, want 0/0/11/11", ramREN, ramWEN, dwait, iwait);
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0) begin
            errors++;
            $display("FAIL t5_idle: ramREN=%b, want 0", ramREN);
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h480 || iwait !== 2'b01) begin
            errors++;
            $display("FAIL t5_after_abort: ren=%b addr=%h iwait=%b, want 1/480/01", ramREN, ramaddr, iwait);
        end
        next_cycle();
        iREN = 2'b00;
        ramstate = 2'd1;
        dWEN = 2'b01;
        daddr[31:0] = 32'h500;
        dstore[31:0] = 32'h55;
        @(negedge CLK);
        next_cycle();
        @(negedge CLK);
        checks++;
        if (ramWEN !== 1'b1 || ramstore !== 32'h55) begin
            errors++;
            $display("FAIL t5_write: wen=%b store=%h, want 1/55", ramWEN, ramstore);
        end
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (ramWEN !== 1'b0 || ramREN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0 ||
            dwait !== 2'b11 || iwait !== 2'b11 || dload !== 64'h0 || iload !== 64'h0) begin
            errors++;
            $display("FAIL t5_async_rst: wen=%b ren=%b addr=%h store=%h dwait=%b iwait=%b, want reset values",
                     ramWEN, ramREN, ramaddr, ramstore, dwait, iwait);
        end
`ifdef MEMARB_STATS_EN
        checks++;
        if (stat_grants !== 32'h0 || stat_stalls !== 32'h0) begin
            errors++;
            $display("FAIL t5_stats_rst: grants=%0d stalls=%0d, want 0/0", stat_grants, stat_stalls);
        end
`endif
        next_cycle();
        dWEN = 2'b00;
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        iREN = '0;
        dREN = '0;
        dWEN = '0;
        iaddr = '0;
        daddr = '0;
        dstore = '0;
        ramload = '0;
        ramstate = 2'd0;
        test_reset();
        test_single_iread();
        test_d_beats_i();
        test_round_robin();
        test_error_retry();
        test_abort_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
